// File: rtl/voq_ingress_port_if.sv
// Ingress port bus: packet input, scheduler dequeue handshake, crossbar output
// and status. The producer/scheduler/crossbar side uses master, the port uses slave.
interface voq_ingress_port_if #(
  parameter int NUM_VOQ = 4
) ();
  localparam int VW = $clog2(NUM_VOQ);

  logic               in_valid;
  logic [31:0]        in_data;
  logic               deq_en;
  logic [VW-1:0]      deq_sel;
  logic [NUM_VOQ-1:0] voq_empty;
  logic [NUM_VOQ-1:0] voq_full;
  logic               deq_ready;
  logic               out_valid;
  logic [31:0]        out_data;
  logic               out_sop;
  logic               out_eop;
  logic [15:0]        drop_cnt;

  modport master (
    output in_valid, in_data, deq_en, deq_sel,
    input  voq_empty, voq_full, deq_ready, out_valid, out_data, out_sop, out_eop, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, deq_en, deq_sel,
    output voq_empty, voq_full, deq_ready, out_valid, out_data, out_sop, out_eop, drop_cnt
  );
endinterface

// File: rtl/voq_ingress_port.sv
// Switch ingress port: packets land in fixed-size slots of a shared buffer,
// {slot,len} descriptors are queued per egress VOQ, and a scheduler dequeue
// streams the head packet of a VOQ to the crossbar with sop/eop framing.
module voq_ingress_port #(
  parameter int NUM_VOQ    = 4,
  parameter int SLOTS      = 64,
  parameter int SLOT_WORDS = 16,
  parameter int VOQ_DEPTH  = 16,
  parameter int STAMP_EN   = 1
) (
  input logic               clk,
  input logic               reset,
  voq_ingress_port_if.slave bus
);
  localparam int VW = $clog2(NUM_VOQ);
  localparam int SW = $clog2(SLOTS);
  localparam int PW = $clog2(VOQ_DEPTH);
  localparam int AW = $clog2(SLOTS * SLOT_WORDS);
  // Longest acceptable length, clipped to what the 6-bit header field can express.
  localparam logic [6:0] MAX_LEN = (SLOT_WORDS > 63) ? 7'd63 : 7'(SLOT_WORDS);

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [5:0]    len;
  } desc_t;

  typedef enum logic [1:0] {I_IDLE, I_WRITE, I_DROP} in_state_e;
  typedef enum logic       {O_IDLE, O_READ}          out_state_e;

  function automatic logic [AW-1:0] word_addr(input logic [SW-1:0] s, input logic [5:0] c);
    return AW'(s) * AW'(SLOT_WORDS) + AW'(c);
  endfunction

  // ---------------------------------------------------------------- time
  logic [31:0] time_q, time_d;

  // Free-running stamp source, wraps naturally.
  always_comb time_d = time_q + 32'd1;

  // Time counter register.
  always_ff @(posedge clk) begin
    if (reset) time_q <= '0;
    else       time_q <= time_d;
  end

  // ---------------------------------------------------------- free list
  // Reset leaves the list full (wr pointer one lap ahead of rd) holding 0..SLOTS-1.
  logic [SW-1:0] fl_mem [SLOTS];
  logic [SW:0]   fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d;
  logic          fl_empty, fl_pop, fl_push;
  logic [SW-1:0] fl_head, fl_push_slot;

  assign fl_empty = (fl_rd_q == fl_wr_q);
  assign fl_head  = fl_mem[fl_rd_q[SW-1:0]];

  // Free-list pointer advance; push and pop in one cycle leave occupancy unchanged.
  always_comb begin
    fl_rd_d = fl_rd_q + {{SW{1'b0}}, fl_pop};
    fl_wr_d = fl_wr_q + {{SW{1'b0}}, fl_push};
  end

  // Free-list pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fl_rd_q <= '0;
      fl_wr_q <= {1'b1, {SW{1'b0}}};
    end else begin
      fl_rd_q <= fl_rd_d;
      fl_wr_q <= fl_wr_d;
    end
  end

  // Free-list storage, reloaded with every slot index on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) fl_mem[i] <= SW'(i);
    end else if (fl_push) begin
      fl_mem[fl_wr_q[SW-1:0]] <= fl_push_slot;
    end
  end

  // ---------------------------------------------------- descriptor FIFOs
  desc_t                    desc_mem [NUM_VOQ*VOQ_DEPTH];
  logic [NUM_VOQ-1:0][PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_VOQ-1:0]       empty, full;
  logic                     enq_en, deq_go;
  logic [VW-1:0]            enq_dest;
  desc_t                    enq_desc, deq_desc;

  for (genvar v = 0; v < NUM_VOQ; v++) begin : g_flag
    assign empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
    assign full[v]  = ((wr_ptr_q[v] ^ rd_ptr_q[v]) == {1'b1, {PW{1'b0}}});
  end

  assign deq_desc = desc_mem[{bus.deq_sel, rd_ptr_q[bus.deq_sel][PW-1:0]}];

  // Per-VOQ pointer advance on enqueue and dequeue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_en) wr_ptr_d[enq_dest]    = wr_ptr_q[enq_dest] + (PW+1)'(1);
    if (deq_go) rd_ptr_d[bus.deq_sel] = rd_ptr_q[bus.deq_sel] + (PW+1)'(1);
  end

  // VOQ pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Descriptor storage write.
  always_ff @(posedge clk) begin
    if (enq_en) desc_mem[{enq_dest, wr_ptr_q[enq_dest][PW-1:0]}] <= enq_desc;
  end

  // ---------------------------------------------------------- input FSM
  in_state_e     in_state_q, in_state_d;
  logic [5:0]    cnt_q, cnt_d, len_q, len_d;
  logic [VW-1:0] dest_q, dest_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   drop_q, drop_d;
  logic [5:0]    hdr_len;
  logic [VW-1:0] hdr_dest;
  logic          hdr_bad, drop_inc, wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  assign hdr_len  = bus.in_data[26:21];
  assign hdr_dest = bus.in_data[28+VW-1:28];
  assign hdr_bad  = (hdr_len == 6'd0) || ({1'b0, hdr_len} > MAX_LEN) || fl_empty || full[hdr_dest];

  // Input state register and packet context.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q <= I_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      slot_q     <= '0;
      drop_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      dest_q     <= dest_d;
      slot_q     <= slot_d;
      drop_q     <= drop_d;
    end
  end

  // Input next state: header decides store/drop; body counts to len-1.
  // Bad headers of length 0 or 1 have no body, so they stay in IDLE.
  always_comb begin
    in_state_d = in_state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    dest_d     = dest_q;
    slot_d     = slot_q;
    if (bus.in_valid) begin
      case (in_state_q)
        I_IDLE: begin
          len_d  = hdr_len;
          dest_d = hdr_dest;
          cnt_d  = 6'd1;
          if (hdr_bad) begin
            in_state_d = (hdr_len > 6'd1) ? I_DROP : I_IDLE;
          end else begin
            slot_d     = fl_head;
            in_state_d = (hdr_len == 6'd1) ? I_IDLE : I_WRITE;
          end
        end
        I_WRITE, I_DROP: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) in_state_d = I_IDLE;
        end
        default: in_state_d = I_IDLE;
      endcase
    end
  end

  // Input outputs: memory write, slot pop, descriptor enqueue, drop count.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = bus.in_data;
    enq_en   = 1'b0;
    enq_dest = dest_q;
    enq_desc = '{slot: slot_q, len: len_q};
    fl_pop   = 1'b0;
    drop_inc = 1'b0;
    if (bus.in_valid) begin
      case (in_state_q)
        I_IDLE: begin
          if (hdr_bad) begin
            drop_inc = 1'b1;
          end else begin
            fl_pop  = 1'b1;
            wr_en   = 1'b1;
            wr_addr = word_addr(fl_head, 6'd0);
            if (hdr_len == 6'd1) begin
              enq_en   = 1'b1;
              enq_dest = hdr_dest;
              enq_desc = '{slot: fl_head, len: hdr_len};
            end
          end
        end
        I_WRITE: begin
          wr_en   = 1'b1;
          wr_addr = word_addr(slot_q, cnt_q);
          if ((STAMP_EN != 0) && (cnt_q == 6'd2)) wr_data = time_q;
          if (cnt_q == len_q - 6'd1) enq_en = 1'b1;
        end
        default: ;
      endcase
    end
    drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  // --------------------------------------------------------- output FSM
  out_state_e    out_state_q, out_state_d;
  logic [SW-1:0] rslot_q, rslot_d;
  logic [5:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic          rd_en, ovld_q, ovld_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rdata_q;

  // An enqueue landing this cycle is not visible here: empty comes from registered pointers.
  assign deq_go = bus.deq_en && (out_state_q == O_IDLE) && !empty[bus.deq_sel];

  // Output state register, read context and framing pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= O_IDLE;
      rslot_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      ovld_q      <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      rslot_q     <= rslot_d;
      rlen_q      <= rlen_d;
      rcnt_q      <= rcnt_d;
      ovld_q      <= ovld_d;
      osop_q      <= osop_d;
      oeop_q      <= oeop_d;
    end
  end

  // Output next state: latch the head descriptor, then one address per cycle.
  always_comb begin
    out_state_d = out_state_q;
    rslot_d     = rslot_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    case (out_state_q)
      O_IDLE: begin
        if (deq_go) begin
          out_state_d = O_READ;
          rslot_d     = deq_desc.slot;
          rlen_d      = deq_desc.len;
          rcnt_d      = 6'd0;
        end
      end
      O_READ: begin
        rcnt_d = rcnt_q + 6'd1;
        if (rcnt_q == rlen_q - 6'd1) out_state_d = O_IDLE;
      end
      default: out_state_d = O_IDLE;
    endcase
  end

  // Output outputs: read address plus framing bits aligned to the 1-cycle read.
  always_comb begin
    rd_en        = (out_state_q == O_READ);
    rd_addr      = word_addr(rslot_q, rcnt_q);
    ovld_d       = rd_en;
    osop_d       = rd_en && (rcnt_q == 6'd0);
    oeop_d       = rd_en && (rcnt_q == rlen_q - 6'd1);
    // rslot_q still holds the packet's slot during its eop cycle.
    fl_push      = oeop_q;
    fl_push_slot = rslot_q;
  end

  // ------------------------------------------------------- data memory
  logic [31:0] dmem [SLOTS*SLOT_WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) dmem[wr_addr] <= wr_data;
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (reset)      rdata_q <= '0;
    else if (rd_en) rdata_q <= dmem[rd_addr];
  end

  assign bus.voq_empty = empty;
  assign bus.voq_full  = full;
  assign bus.deq_ready = (out_state_q == O_IDLE);
  assign bus.out_valid = ovld_q;
  assign bus.out_data  = rdata_q;
  assign bus.out_sop   = osop_q;
  assign bus.out_eop   = oeop_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_voq_ingress_port.sv
// Scoreboard bench for voq_ingress_port: a packet model per VOQ is built as
// packets are driven, moved to an expected-word queue on dequeue and compared
// word by word as the crossbar output appears.
module tb_voq_ingress_port;
  localparam int NV = 4;
  localparam int NS = 64;
  localparam int SWD = 16;
  localparam int VD = 16;
  localparam int ST = 1;

  typedef struct {
    int          dest;
    int          len;
    logic [31:0] w [SWD];
  } pkt_t;

  logic clk, reset;
  voq_ingress_port_if #(.NUM_VOQ(NV)) dut_if ();

  voq_ingress_port #(
    .NUM_VOQ(NV), .SLOTS(NS), .SLOT_WORDS(SWD), .VOQ_DEPTH(VD), .STAMP_EN(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if.slave)
  );

  int          checks, failures;
  int          slots_used, exp_drop;
  logic [31:0] tcnt;
  pkt_t        mq [$];
  logic [33:0] exp_q [$];
  logic [33:0] mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time counter, same reset/increment behaviour as the port's stamp source.
  always @(posedge clk) begin
    if (reset) tcnt <= '0;
    else       tcnt <= tcnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int vq_count(input int d);
    int n;
    n = 0;
    foreach (mq[i]) if (mq[i].dest == d) n++;
    return n;
  endfunction

  function automatic logic [NV-1:0] exp_empty();
    logic [NV-1:0] m;
    m = '1;
    foreach (mq[i]) m[mq[i].dest] = 1'b0;
    return m;
  endfunction

  function automatic logic [NV-1:0] exp_full();
    logic [NV-1:0] m;
    for (int v = 0; v < NV; v++) m[v] = (vq_count(v) >= VD);
    return m;
  endfunction

  // Output monitor: every valid word must be the next expected {sop,eop,data}.
  always @(negedge clk) begin
    if (!reset && dut_if.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", {dut_if.out_sop, dut_if.out_eop, dut_if.out_data}, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_word", {dut_if.out_sop, dut_if.out_eop, dut_if.out_data}, mon_e);
        if (mon_e[32]) slots_used--;
      end
    end
  end

  // Drive one packet (nwords words, header carries len/dest); model decides acceptance.
  task automatic send(input int dest, input int len, input int nwords);
    pkt_t        p;
    bit          ok;
    logic [31:0] w;
    logic [5:0]  l6;
    logic [1:0]  d2;
    ok = (len >= 1) && (len <= SWD) && (slots_used < NS) && (vq_count(dest) < VD);
    p.dest = dest;
    p.len  = len;
    l6 = 6'(len);
    d2 = 2'(dest);
    for (int i = 0; i < nwords; i++) begin
      @(posedge clk); #1;
      w = $urandom;
      if (i == 0) begin
        w[26:21] = l6;
        w[29:28] = d2;
      end
      dut_if.in_valid = 1'b1;
      dut_if.in_data  = w;
      if (i < SWD) p.w[i] = (i == 2 && ST != 0) ? tcnt : w;
    end
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
    if (ok) begin
      mq.push_back(p);
      slots_used++;
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  // Dequeue request to sel once the engine is ready; checks latency or rejection.
  task automatic deq(input int sel);
    int   to, idx;
    pkt_t p;
    to = 0;
    @(posedge clk); #1;
    while (!dut_if.deq_ready && to < 100) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 100) chk("deq_ready_timeout", 64'd0, 64'd1);
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].dest == sel) idx = i;
    dut_if.deq_en  = 1'b1;
    dut_if.deq_sel = 2'(sel);
    if (idx >= 0) begin
      p = mq[idx];
      mq.delete(idx);
      for (int k = 0; k < p.len; k++) exp_q.push_back({k == 0, k == p.len - 1, p.w[k]});
    end
    @(posedge clk); #1;
    dut_if.deq_en = 1'b0;
    @(negedge clk);
    if (idx >= 0) begin
      chk("deq_busy_ready", dut_if.deq_ready, 1'b0);
      chk("lat1_no_valid", dut_if.out_valid, 1'b0);
      @(negedge clk);
      chk("lat2_sop", {dut_if.out_valid, dut_if.out_sop}, 2'b11);
    end else begin
      chk("rej_ready", dut_if.deq_ready, 1'b1);
      chk("rej_valid", dut_if.out_valid, 1'b0);
      @(negedge clk);
      chk("rej_valid2", dut_if.out_valid, 1'b0);
    end
  endtask

  // Wait for the output stream to finish everything already dequeued.
  task automatic wait_out();
    int to;
    to = 0;
    while ((exp_q.size() > 0 || dut_if.out_valid) && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (to >= 400) chk("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  // Dequeue every modelled packet, oldest first, back to back.
  task automatic drain();
    while (mq.size() > 0) deq(mq[0].dest);
    wait_out();
    chk("drain_empty", dut_if.voq_empty, exp_empty());
  endtask

  task automatic chk_status(input string tag);
    @(negedge clk);
    chk({tag, "_empty"}, dut_if.voq_empty, exp_empty());
    chk({tag, "_full"}, dut_if.voq_full, exp_full());
    chk({tag, "_drop"}, dut_if.drop_cnt, 16'(exp_drop));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] h;
    checks = 0; failures = 0; slots_used = 0; exp_drop = 0;
    reset = 1'b1;
    dut_if.in_valid = 1'b0; dut_if.in_data = '0;
    dut_if.deq_en = 1'b0; dut_if.deq_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_empty", dut_if.voq_empty, 4'hF);
    chk("rst_full", dut_if.voq_full, 4'h0);
    chk("rst_ready", dut_if.deq_ready, 1'b1);
    chk("rst_out", {dut_if.out_valid, dut_if.out_sop, dut_if.out_eop, dut_if.out_data}, 35'h0);
    chk("rst_drop", dut_if.drop_cnt, 16'h0);

    // Single 4-word packet to VOQ2 with a stamped word 2.
    send(2, 4, 4);
    @(negedge clk);
    chk("p4_empty", dut_if.voq_empty, 4'b1011);
    deq(2);
    wait_out();
    chk("p4_empty_after", dut_if.voq_empty, 4'hF);

    // FIFO order in VOQ0, back-to-back dequeues, max-length packet.
    send(0, 3, 3);
    send(0, SWD, SWD);
    send(3, 2, 2);
    chk_status("three");
    drain();

    // Every slot is back: SLOTS packets fit, filling every VOQ.
    for (int i = 0; i < NS; i++) send(i % NV, 1 + (i % 3), 1 + (i % 3));
    chk_status("fill");
    chk("fill_full", dut_if.voq_full, 4'hF);
    // Empty all but VOQ1, then overflow VOQ1.
    while (vq_count(0) + vq_count(2) + vq_count(3) > 0) begin
      for (int k = 0; k < mq.size(); k++) begin
        if (mq[k].dest != 1) begin
          deq(mq[k].dest);
          break;
        end
      end
    end
    wait_out();
    chk("ovf_full1", dut_if.voq_full, 4'b0010);
    send(1, 2, 2);
    chk_status("ovf");
    chk("ovf_drop1", dut_if.drop_cnt, 16'd1);
    send(0, 3, 3);
    chk_status("after_ovf");
    drain();

    // Malformed lengths: 0 and SLOT_WORDS+1 with its trailing words.
    send(2, 0, 1);
    send(3, SWD + 1, SWD + 1);
    chk_status("bad_len");
    chk("bad_len_drop", dut_if.drop_cnt, 16'd3);
    send(3, 5, 5);
    chk_status("resync");
    drain();

    // Dequeue of an empty VOQ, and a dequeue while busy.
    deq(1);
    chk("empty_deq_state", dut_if.voq_empty, 4'hF);
    send(2, 8, 8);
    send(3, 2, 2);
    deq(2);
    @(posedge clk); #1;
    dut_if.deq_en = 1'b1; dut_if.deq_sel = 2'd3;
    @(posedge clk); #1;
    dut_if.deq_en = 1'b0;
    @(negedge clk);
    chk("busy_deq_ignored", dut_if.voq_empty[3], 1'b0);
    wait_out();
    drain();

    // Reset in the middle of a WRITE burst.
    send(0, 3, 3);
    h = $urandom; h[26:21] = 6'd8; h[29:28] = 2'd1;
    @(posedge clk); #1; dut_if.in_valid = 1'b1; dut_if.in_data = h;
    @(posedge clk); #1; dut_if.in_data = $urandom;
    @(posedge clk); #1; dut_if.in_data = $urandom; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0; dut_if.in_valid = 1'b0;
    mq.delete(); exp_q.delete(); slots_used = 0; exp_drop = 0;
    chk_status("mid_rst");
    chk("mid_rst_ready", dut_if.deq_ready, 1'b1);
    for (int i = 0; i < NS; i++) send((i + 1) % NV, 3 - (i % 3), 3 - (i % 3));
    chk_status("mid_rst_fill");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
